// File: rtl/uart_cfg_ctrl_pkg.sv
// Shared types for the multi-channel UART configuration controller.
// Holds opcode and FSM state encodings, the reserved mode value and a counter-width helper.
package uart_cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_RESTORE = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_DATA = 2'b01,
    ST_CHECK     = 2'b10,
    ST_DONE      = 2'b11
  } state_e;

  localparam logic [1:0] MODE_RESERVED = 2'b10;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cfg_ctrl_timeout.sv
// Saturating wait counter for the data byte of a WRITE command.
// expired is high while enabled once the count has reached TIMEOUT_CYC-1.
module uart_cfg_timeout
  import uart_cfg_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Multi-channel UART configuration controller: decodes command bytes from the RX path and
// applies write / read-back / restore operations to NUM_CH channel config registers.
module uart_cfg_ctrl
  import uart_cfg_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       NUM_CH      = 4,
  parameter logic [DATA_W-1:0] RESET_CFG   = DATA_W'(8'b00001100),
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_ready,
  input  logic [DATA_W-1:0]        data_in,
  output logic [NUM_CH*DATA_W-1:0] cfg_out,
  output logic [NUM_CH-1:0]        cfg_update,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     ack,
  output logic                     nack,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state, state_nxt;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] dat_q;
  logic              timed_out_q;
  logic [DATA_W-1:0] cfg_q [NUM_CH];
  logic              expired;

  opcode_e           op;
  logic [5:0]        ch;
  logic [IDX_W-1:0]  idx;
  logic              ch_ok;
  logic              mode_bad;
  logic              cmd_ok;

  assign op       = opcode_e'(hdr_q[DATA_W-1 -: 2]);
  assign ch       = hdr_q[5:0];
  assign idx      = ch[IDX_W-1:0];
  assign ch_ok    = {26'd0, ch} < NUM_CH;
  assign mode_bad = (dat_q[5:4] == MODE_RESERVED);
  assign busy     = (state != ST_IDLE);

  if (DATA_W > 8) begin : g_hdr_pad
    logic hdr_pad_unused;
    assign hdr_pad_unused = ^hdr_q[DATA_W-3:6];
  end

  uart_cfg_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_WAIT_DATA),
    .enable  (state == ST_WAIT_DATA),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (data_ready) begin
          state_nxt = (opcode_e'(data_in[DATA_W-1 -: 2]) == OP_WRITE) ? ST_WAIT_DATA : ST_CHECK;
        end
      end
      ST_WAIT_DATA: if (data_ready || expired) state_nxt = ST_CHECK;
      ST_CHECK:     state_nxt = ST_DONE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ok = 1'b1;
    case (op)
      OP_WRITE: cmd_ok = ch_ok && !timed_out_q && !mode_bad;
      OP_READ:  cmd_ok = ch_ok;
      default:  cmd_ok = 1'b1;
    endcase
  end

  // Status pulses are registered out of CHECK so they coincide with the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_q       <= '0;
      dat_q       <= '0;
      timed_out_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) cfg_q[c] <= RESET_CFG;
      cfg_update  <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      ack         <= 1'b0;
      nack        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cfg_update <= '0;
      rd_valid   <= 1'b0;
      ack        <= 1'b0;
      nack       <= 1'b0;
      overrun    <= data_ready && ((state == ST_CHECK) || (state == ST_DONE));
      case (state)
        ST_IDLE: begin
          if (data_ready) begin
            hdr_q       <= data_in;
            timed_out_q <= 1'b0;
          end
        end
        ST_WAIT_DATA: begin
          if (data_ready)   dat_q       <= data_in;
          else if (expired) timed_out_q <= 1'b1;
        end
        ST_CHECK: begin
          ack  <= cmd_ok;
          nack <= !cmd_ok;
          if (cmd_ok) begin
            case (op)
              OP_WRITE: begin
                cfg_q[idx]      <= dat_q;
                cfg_update[idx] <= 1'b1;
              end
              OP_READ: begin
                rd_data  <= cfg_q[idx];
                rd_valid <= 1'b1;
              end
              OP_RESTORE: begin
                for (int unsigned c = 0; c < NUM_CH; c++) cfg_q[c] <= RESET_CFG;
                cfg_update <= '1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) cfg_out[c*DATA_W +: DATA_W] = cfg_q[c];
  end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Scoreboard bench for uart_cfg_ctrl (4 channels, 8-bit, 16-cycle timeout).
// Stimulus pushes hand-computed responses; a negedge monitor pops and compares them.
module tb_uart_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  data_in = '0;
  logic [31:0] cfg_out;
  logic [3:0]  cfg_update;
  logic [7:0]  rd_data;
  logic        rd_valid, ack, nack, overrun, busy;

  uart_cfg_ctrl #(
    .DATA_W      (8),
    .NUM_CH      (4),
    .RESET_CFG   (8'h0C),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .data_in    (data_in),
    .cfg_out    (cfg_out),
    .cfg_update (cfg_update),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ack        (ack),
    .nack       (nack),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        ack;
    logic        nack;
    logic        rv;
    logic [7:0]  rd;
    logic [3:0]  upd;
    logic [31:0] cfg;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int unsigned ovr_cnt = 0;
  int unsigned ovr_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (ack || nack || rd_valid || (cfg_update != 4'b0))) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response: ack=%0b nack=%0b rd_valid=%0b upd=%b at cycle %0d, expected none",
                 ack, nack, rd_valid, cfg_update, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_cycle"},    cyc,        e.at);
        chk({e.name, "_ack"},      ack,        e.ack);
        chk({e.name, "_nack"},     nack,       e.nack);
        chk({e.name, "_rd_valid"}, rd_valid,   e.rv);
        chk({e.name, "_rd_data"},  rd_data,    e.rd);
        chk({e.name, "_upd"},      cfg_update, e.upd);
        chk({e.name, "_cfg"},      cfg_out,    e.cfg);
      end
    end
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  task automatic drive(input logic [7:0] b, output int unsigned t);
    @(posedge clk); #1;
    data_ready = 1'b1;
    data_in    = b;
    t          = cyc;
    @(posedge clk); #1;
    data_ready = 1'b0;
  endtask

  task automatic push(input string name, input logic a, input logic n, input logic rv,
                      input logic [7:0] rd, input logic [3:0] upd, input logic [31:0] cfg,
                      input int unsigned at);
    exp_t x;
    x.name = name; x.ack = a; x.nack = n; x.rv = rv;
    x.rd = rd; x.upd = upd; x.cfg = cfg; x.at = at;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d responses pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Header + data; response expected two cycles after the data byte.
  task automatic wr(input string name, input logic [7:0] h, input logic [7:0] d,
                    input logic a, input logic [3:0] upd, input logic [7:0] rd, input logic [31:0] cfg);
    int unsigned th, td;
    drive(h, th);
    drive(d, td);
    push(name, a, !a, 1'b0, rd, upd, cfg, td + 2);
    drain(name);
  endtask

  task automatic hdr(input string name, input logic [7:0] h, input logic a, input logic rv,
                     input logic [3:0] upd, input logic [7:0] rd, input logic [31:0] cfg);
    int unsigned t;
    drive(h, t);
    push(name, a, !a, rv, rd, upd, cfg, t + 2);
    drain(name);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1, t2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg",      cfg_out,    32'h0C0C0C0C);
    chk("rst_ack",      ack,        1'b0);
    chk("rst_nack",     nack,       1'b0);
    chk("rst_busy",     busy,       1'b0);
    chk("rst_upd",      cfg_update, 4'b0);
    chk("rst_rd_data",  rd_data,    8'h00);
    rst = 1'b1;

    // Reset during WAIT_DATA drops the command; the next byte is a fresh header (NOP).
    drive(8'h41, t1);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cfg",  cfg_out, 32'h0C0C0C0C);
    hdr("nop_after_rst", 8'h33, 1'b1, 1'b0, 4'b0000, 8'h00, 32'h0C0C0C0C);

    wr("wr_ch2",      8'h42, 8'h15, 1'b1, 4'b0100, 8'h00, 32'h0C150C0C);
    wr("wr_ch2_same", 8'h42, 8'h15, 1'b1, 4'b0100, 8'h00, 32'h0C150C0C);
    // 0x25 and 0x2F both carry data[5:4]=2'b10, the reserved mode.
    wr("wr_resv_25",  8'h42, 8'h25, 1'b0, 4'b0000, 8'h00, 32'h0C150C0C);
    wr("wr_resv_2f",  8'h41, 8'h2F, 1'b0, 4'b0000, 8'h00, 32'h0C150C0C);
    wr("wr_bad_ch",   8'h45, 8'h01, 1'b0, 4'b0000, 8'h00, 32'h0C150C0C);

    hdr("rd_ch2",     8'h82, 1'b1, 1'b1, 4'b0000, 8'h15, 32'h0C150C0C);
    hdr("rd_bad_ch",  8'h86, 1'b0, 1'b0, 4'b0000, 8'h15, 32'h0C150C0C);

    // WAIT_DATA occupies cycles t1+1..t1+16; expiry then costs CHECK and DONE.
    drive(8'h40, t1);
    chk("to_busy", busy, 1'b1);
    push("timeout", 1'b0, 1'b1, 1'b0, 8'h15, 4'b0000, 32'h0C150C0C, t1 + 18);
    drain("timeout");

    drive(8'h40, t1);
    while (cyc < t1 + 15) begin
      @(posedge clk); #1;
    end
    drive(8'h07, t2);
    push("last_cycle_data", 1'b1, 1'b0, 1'b0, 8'h15, 4'b0001, 32'h0C150C07, t2 + 2);
    drain("last_cycle_data");

    drive(8'h43, t1);
    drive(8'h11, t2);
    data_ready = 1'b1;
    data_in    = 8'hFF;
    push("wr_overrun", 1'b1, 1'b0, 1'b0, 8'h15, 4'b1000, 32'h11150C07, t2 + 2);
    @(posedge clk); #1;
    data_ready = 1'b0;
    drain("wr_overrun");
    chk("overrun_count", ovr_cnt, 1);
    chk("overrun_cycle", ovr_cyc, t2 + 2);

    hdr("restore",    8'hC0, 1'b1, 1'b0, 4'b1111, 8'h15, 32'h0C0C0C0C);
    hdr("rd_ch3",     8'h83, 1'b1, 1'b1, 4'b0000, 8'h0C, 32'h0C0C0C0C);

    chk("end_busy",          busy,    1'b0);
    chk("end_overrun_count", ovr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
